pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage RV32I pipeline. It replaces the forwarding-only hazard unit. Beyond M/W operand forwarding, it adds:
- load-use interlock with a configurable bubble count;
- branch/jump flush of D and E;
- a data-memory wait handshake that freezes F/D/E/M while a slow memory responds.

It sits beside the stage registers in the pipeline top and drives their stall/flush enables.

---
 rtl/pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use interlock, branch flush, dmem wait.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_events performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  RegWriteW,
  input  logic                  dmem_req_m,
  input  logic                  dmem_ready,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [REG_ADDR_W-1:0] X0      = '0;
  localparam logic [CNT_W-1:0]      LU_LOAD = CNT_W'(LOAD_USE_BUBBLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ret_q, ret_d;

  logic lu_hit;
  logic mem_wait;

  assign lu_hit   = ResultSrcE && (RD_E != X0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  assign mem_wait = dmem_req_m && !dmem_ready;

  // M/W operand forwarding, M has priority; forced to regfile while in reset
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      if (RegWriteM && (RD_M != X0) && (RD_M == Rs1_E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RD_W != X0) && (RD_W == Rs1_E)) ForwardAE = 2'b01;
      if (RegWriteM && (RD_M != X0) && (RD_M == Rs2_E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RD_W != X0) && (RD_W == Rs2_E)) ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  // Next state and stall/flush enables; priority mem_wait > PCSrcE > lu_hit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_wait) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW  = 1'b1;
          ret_d   = 1'b0;
          state_d = MEM_WAIT;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lu_hit) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (LOAD_USE_BUBBLES > 1) begin
            cnt_d   = LU_LOAD;
            state_d = LU_STALL;
          end
        end
      end

      LU_STALL: begin
        if (mem_wait) begin
          // Counter is frozen; the return flag brings us back here afterwards
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW  = 1'b1;
          ret_d   = 1'b1;
          state_d = MEM_WAIT;
        end else if (PCSrcE) begin
          FlushD  = 1'b1;
          FlushE  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      MEM_WAIT: begin
        if (!dmem_ready) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW = 1'b1;
        end else begin
          state_d = ret_q ? LU_STALL : IDLE;
          ret_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ret_d   = 1'b0;
      end
    endcase

    // Reset overrides everything: no stalls, all flushes asserted
    if (!rst) begin
      {StallF, StallD, StallE, StallM} = 4'b0000;
      {FlushD, FlushE, FlushW}         = 3'b111;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // FlushD is only ever raised by PCSrcE outside of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushD) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with LOAD_USE_BUBBLES=3.
// Covers HAZARD_PERF_CNT_EN counters when the macro is defined.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, PCSrcE, RegWriteM, RegWriteW, dmem_req_m, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  logic [6:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b0000111;
  localparam logic [6:0] C_LU    = 7'b1100010;
  localparam logic [6:0] C_BR    = 7'b0000110;
  localparam logic [6:0] C_MWAIT = 7'b1111001;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W      (5),
    .LOAD_USE_BUBBLES(3),
    .CNT_W           (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1_D     (Rs1_D),
    .Rs2_D     (Rs2_D),
    .Rs1_E     (Rs1_E),
    .Rs2_E     (Rs2_E),
    .RD_E      (RD_E),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .RD_M      (RD_M),
    .RegWriteM (RegWriteM),
    .RD_W      (RD_W),
    .RegWriteW (RegWriteW),
    .dmem_req_m(dmem_req_m),
    .dmem_ready(dmem_ready),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; RD_E = '0; RD_M = '0; RD_W = '0;
    ResultSrcE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    dmem_req_m = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    RD_E = 5'd7; ResultSrcE = 1'b1; Rs2_D = 5'd7;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    RD_M = 5'd5; RegWriteM = 1'b1; Rs1_E = 5'd5;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_fwdA", 32'(ForwardAE), 32'd0);
    #10 rst = 1'b1;
    tick();

    // Forwarding
    clr();
    RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1; Rs1_E = 5'd5; Rs2_E = 5'd5;
    #1;
    chk("fwd_m_prio_A", 32'(ForwardAE), 32'h2);
    chk("fwd_m_prio_B", 32'(ForwardBE), 32'h2);
    chk("idle_ctrl", 32'(ctrl), 32'(C_NONE));
    Rs1_E = 5'd0; #1;
    chk("fwd_x0_A", 32'(ForwardAE), 32'h0);
    chk("fwd_x0_keepB", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0; Rs1_E = 5'd5; #1;
    chk("fwd_w_A", 32'(ForwardAE), 32'h1);
    RD_W = 5'd0; #1;
    chk("fwd_w_x0_A", 32'(ForwardAE), 32'h0);
    RD_W = 5'd9; RegWriteW = 1'b1; Rs2_E = 5'd9; RD_M = 5'd3; RegWriteM = 1'b1; #1;
    chk("fwd_w_B", 32'(ForwardBE), 32'h1);

    // No load-use hit cases
    clr(); RD_E = 5'd0; ResultSrcE = 1'b1; Rs1_D = 5'd0; #1;
    chk("lu_rd_x0", 32'(ctrl), 32'(C_NONE));
    RD_E = 5'd4; ResultSrcE = 1'b0; Rs1_D = 5'd4; #1;
    chk("lu_not_load", 32'(ctrl), 32'(C_NONE));

    // Load-use with 3 bubbles
    clr(); set_lu(); #1;
    chk("lu_b1", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu_b2", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu_b3", 32'(ctrl), 32'(C_LU));
    tick();
    clr(); #1;
    chk("lu_release", 32'(ctrl), 32'(C_NONE));

    // Branch with lu_hit in IDLE: flush wins, stays IDLE
    set_lu(); PCSrcE = 1'b1; #1;
    chk("br_over_lu", 32'(ctrl), 32'(C_BR));
    tick();
    clr(); #1;
    chk("br_stays_idle", 32'(ctrl), 32'(C_NONE));

    // Mem wait during LU_STALL with counter=1
    set_lu(); #1;
    chk("lu2_b1", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu2_b2", 32'(ctrl), 32'(C_LU));
    tick();
    clr(); dmem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lu_mwait_%0d", i), 32'(ctrl), 32'(C_MWAIT));
      tick();
    end
    dmem_ready = 1'b1; #1;
    chk("lu_mready", 32'(ctrl), 32'(C_NONE));
    tick();
    clr(); #1;
    chk("lu_resume_bubble", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu_resume_idle", 32'(ctrl), 32'(C_NONE));

    // Mem wait from IDLE
    dmem_req_m = 1'b1; #1;
    chk("idle_mwait", 32'(ctrl), 32'(C_MWAIT));
    tick();
    dmem_ready = 1'b1; #1;
    chk("idle_mready", 32'(ctrl), 32'(C_NONE));
    tick();
    clr(); #1;
    chk("idle_after_mem", 32'(ctrl), 32'(C_NONE));

    // Branch during LU_STALL: flush wins, back to IDLE
    set_lu(); tick();
    PCSrcE = 1'b1; #1;
    chk("lu_branch", 32'(ctrl), 32'(C_BR));
    tick();
    clr(); #1;
    chk("lu_branch_idle", 32'(ctrl), 32'(C_NONE));

    // Async reset in the middle of MEM_WAIT
    dmem_req_m = 1'b1; tick();
    RD_M = 5'd5; RegWriteM = 1'b1; Rs1_E = 5'd5; Rs2_E = 5'd5; #1;
    chk("mw_pre_rst_ctrl", 32'(ctrl), 32'(C_MWAIT));
    chk("mw_pre_rst_fwdA", 32'(ForwardAE), 32'h2);
    #1 rst = 1'b0;
    #1;
    chk("mw_rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("mw_rst_fwdA", 32'(ForwardAE), 32'h0);
    chk("mw_rst_fwdB", 32'(ForwardBE), 32'h0);
    #2 rst = 1'b1;
    clr();
    tick();
    chk("post_rst_idle", 32'(ctrl), 32'(C_NONE));

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_zero", stall_cycles, 32'd0);
    chk("perf_flush_zero", flush_events, 32'd0);
    PCSrcE = 1'b1; tick();
    PCSrcE = 1'b0; tick();
    PCSrcE = 1'b1; tick();
    PCSrcE = 1'b0;
    set_lu(); tick(); tick(); tick();
    clr(); tick();
    chk("perf_flush", flush_events, 32'd2);
    chk("perf_stall", stall_cycles, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
